// File: rtl/rv_ctrl_exec_slice.sv
// RV32I control/execute slice: ID-stage control decoder with early branch
// resolution, EX-stage ALU with forwarding muxes, and the EX/MEM register.
module rv_ctrl_exec_slice #(
    parameter int OPERAND_WIDTH         = 32,
    parameter int PROGRAM_ADDRESS_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,

    // ID-stage decode inputs
    input  logic [6:0]                       id_opcode,
    input  logic [2:0]                       id_funct3,
    input  logic [OPERAND_WIDTH-1:0]         id_rs1_data,
    input  logic [OPERAND_WIDTH-1:0]         id_rs2_data,

    // ID-stage control outputs
    output logic                             ctrl_mem_write,
    output logic                             ctrl_mem2reg,
    output logic                             ctrl_reg_write,
    output logic                             ctrl_alu_src,
    output logic                             ctrl_branch_taken,
    output logic                             ctrl_auipc_taken,
    output logic [2:0]                       ctrl_store_size,
    output logic [2:0]                       ctrl_load_size,

    // EX-stage inputs
    input  logic [6:0]                       ex_opcode,
    input  logic [2:0]                       ex_funct3,
    input  logic [6:0]                       ex_funct7,
    input  logic [OPERAND_WIDTH-1:0]         ex_imm,
    input  logic [PROGRAM_ADDRESS_WIDTH-1:0] ex_pc,
    input  logic [OPERAND_WIDTH-1:0]         ex_rs1_data,
    input  logic [OPERAND_WIDTH-1:0]         ex_rs2_data,
    input  logic [OPERAND_WIDTH-1:0]         from_mem,
    input  logic [OPERAND_WIDTH-1:0]         from_wb,
    input  logic                             ex_alu_src,
    input  logic                             ex_auipc_taken,
    input  logic [1:0]                       fwd_left,
    input  logic [1:0]                       fwd_right,
    input  logic [4:0]                       ex_rd_sel,
    input  logic                             ex_mem_write,
    input  logic                             ex_mem2reg,
    input  logic                             ex_reg_write,
    input  logic [2:0]                       ex_load_size,
    input  logic [2:0]                       ex_store_size,

    // EX-stage combinational results
    output logic [OPERAND_WIDTH-1:0]         alu_result,
    output logic [OPERAND_WIDTH-1:0]         write_data,

    // EX/MEM register outputs
    output logic [OPERAND_WIDTH-1:0]         o_alu_result,
    output logic [OPERAND_WIDTH-1:0]         o_write_data,
    output logic [4:0]                       o_rd_sel,
    output logic                             o_ctrl_mem_write,
    output logic                             o_ctrl_mem2reg,
    output logic                             o_ctrl_reg_write,
    output logic [2:0]                       o_ctrl_load_size,
    output logic [2:0]                       o_ctrl_store_size
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] FWD_EX_MEM = 2'd1;
    localparam logic [1:0] FWD_MEM_WB = 2'd2;

    localparam logic [OPERAND_WIDTH-1:0] LINK_OFFSET = OPERAND_WIDTH'(4);

    // Shared ALU core for OP and OP-IMM; 'alt' selects SUB (funct3 000) or SRA (funct3 101).
    function automatic logic [OPERAND_WIDTH-1:0] alu_op(
        input logic [2:0]               f3,
        input logic                     alt,
        input logic [OPERAND_WIDTH-1:0] a,
        input logic [OPERAND_WIDTH-1:0] b
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (f3)
            3'b000:  alu_op = alt ? (a - b) : (a + b);
            3'b001:  alu_op = a << shamt;
            3'b010:  alu_op = {{(OPERAND_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  alu_op = {{(OPERAND_WIDTH-1){1'b0}}, (a < b)};
            3'b100:  alu_op = a ^ b;
            3'b101:  alu_op = alt ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            3'b110:  alu_op = a | b;
            default: alu_op = a & b;
        endcase
    endfunction

    logic                     branch_cond;
    logic [OPERAND_WIDTH-1:0] op_a;
    logic [OPERAND_WIDTH-1:0] op_b;
    logic [OPERAND_WIDTH-1:0] rs2_fwd;
    logic [OPERAND_WIDTH-1:0] pc_ext;
    logic                     unused_funct7_bits;

    // Only funct7[5] selects alternate ops; the remaining bits are don't-care here.
    assign unused_funct7_bits = ^{ex_funct7[6], ex_funct7[4:0]};

    assign pc_ext = {{(OPERAND_WIDTH-PROGRAM_ADDRESS_WIDTH){1'b0}}, ex_pc};

    // Early branch condition evaluated on unforwarded register-file data.
    always_comb begin
        branch_cond = 1'b0;
        case (id_funct3)
            3'b000:  branch_cond = (id_rs1_data == id_rs2_data);
            3'b001:  branch_cond = (id_rs1_data != id_rs2_data);
            3'b100:  branch_cond = ($signed(id_rs1_data) <  $signed(id_rs2_data));
            3'b101:  branch_cond = ($signed(id_rs1_data) >= $signed(id_rs2_data));
            3'b110:  branch_cond = (id_rs1_data <  id_rs2_data);
            3'b111:  branch_cond = (id_rs1_data >= id_rs2_data);
            default: branch_cond = 1'b0;
        endcase
    end

    // Main control decode; unknown opcodes leave every control deasserted.
    always_comb begin
        ctrl_mem_write    = 1'b0;
        ctrl_mem2reg      = 1'b0;
        ctrl_reg_write    = 1'b0;
        ctrl_alu_src      = 1'b0;
        ctrl_branch_taken = 1'b0;
        ctrl_auipc_taken  = 1'b0;
        ctrl_store_size   = 3'b000;
        ctrl_load_size    = 3'b000;
        case (id_opcode)
            OPC_OP: begin
                ctrl_reg_write = 1'b1;
            end
            OPC_OPIMM, OPC_LUI, OPC_JALR: begin
                ctrl_reg_write = 1'b1;
                ctrl_alu_src   = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_reg_write = 1'b1;
                ctrl_mem2reg   = 1'b1;
                ctrl_alu_src   = 1'b1;
                ctrl_load_size = id_funct3;
            end
            OPC_STORE: begin
                ctrl_mem_write  = 1'b1;
                ctrl_alu_src    = 1'b1;
                ctrl_store_size = id_funct3;
            end
            OPC_AUIPC: begin
                ctrl_reg_write   = 1'b1;
                ctrl_alu_src     = 1'b1;
                ctrl_auipc_taken = 1'b1;
            end
            OPC_JAL: begin
                ctrl_reg_write    = 1'b1;
                ctrl_branch_taken = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_branch_taken = branch_cond;
            end
            default: ;
        endcase
    end

    // Forwarding muxes for both source operands; encoding 0 and 3 both mean no forwarding.
    always_comb begin
        case (fwd_left)
            FWD_EX_MEM: op_a = from_mem;
            FWD_MEM_WB: op_a = from_wb;
            default:    op_a = ex_rs1_data;
        endcase
        case (fwd_right)
            FWD_EX_MEM: rs2_fwd = from_mem;
            FWD_MEM_WB: rs2_fwd = from_wb;
            default:    rs2_fwd = ex_rs2_data;
        endcase
        op_b = ex_alu_src ? ex_imm : rs2_fwd;
    end

    assign write_data = rs2_fwd;

    // EX result select; the registered AUIPC flag takes priority over the opcode.
    always_comb begin
        alu_result = '0;
        if (ex_auipc_taken) begin
            alu_result = pc_ext + ex_imm;
        end else begin
            case (ex_opcode)
                OPC_OP:              alu_result = alu_op(ex_funct3, ex_funct7[5], op_a, op_b);
                // OP-IMM has no SUBI: the alternate bit only applies to right shifts.
                OPC_OPIMM:           alu_result = alu_op(ex_funct3,
                                                         ex_funct7[5] && (ex_funct3 == 3'b101),
                                                         op_a, op_b);
                OPC_LOAD, OPC_STORE: alu_result = op_a + ex_imm;
                OPC_LUI:             alu_result = ex_imm;
                OPC_AUIPC:           alu_result = pc_ext + ex_imm;
                // Jumps write back the link address; the target is resolved elsewhere.
                OPC_JAL, OPC_JALR:   alu_result = pc_ext + LINK_OFFSET;
                default:             alu_result = '0;
            endcase
        end
    end

    logic [OPERAND_WIDTH-1:0] alu_result_d,  alu_result_q;
    logic [OPERAND_WIDTH-1:0] write_data_d,  write_data_q;
    logic [4:0]               rd_sel_d,      rd_sel_q;
    logic                     mem_write_d,   mem_write_q;
    logic                     mem2reg_d,     mem2reg_q;
    logic                     reg_write_d,   reg_write_q;
    logic [2:0]               load_size_d,   load_size_q;
    logic [2:0]               store_size_d,  store_size_q;

    assign alu_result_d = alu_result;
    assign write_data_d = write_data;
    assign rd_sel_d     = ex_rd_sel;
    assign mem_write_d  = ex_mem_write;
    assign mem2reg_d    = ex_mem2reg;
    assign reg_write_d  = ex_reg_write;
    assign load_size_d  = ex_load_size;
    assign store_size_d = ex_store_size;

    // EX/MEM pipeline register; reset clears data as well as controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_sel_q     <= '0;
            mem_write_q  <= 1'b0;
            mem2reg_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            load_size_q  <= '0;
            store_size_q <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_sel_q     <= rd_sel_d;
            mem_write_q  <= mem_write_d;
            mem2reg_q    <= mem2reg_d;
            reg_write_q  <= reg_write_d;
            load_size_q  <= load_size_d;
            store_size_q <= store_size_d;
        end
    end

    assign o_alu_result      = alu_result_q;
    assign o_write_data      = write_data_q;
    assign o_rd_sel          = rd_sel_q;
    assign o_ctrl_mem_write  = mem_write_q;
    assign o_ctrl_mem2reg    = mem2reg_q;
    assign o_ctrl_reg_write  = reg_write_q;
    assign o_ctrl_load_size  = load_size_q;
    assign o_ctrl_store_size = store_size_q;

endmodule

// File: tb/tb_rv_ctrl_exec_slice.sv
// Directed bench for rv_ctrl_exec_slice: table-driven decoder and ALU vectors
// plus hand-written reset and EX/MEM register sequences.
module tb_rv_ctrl_exec_slice;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic        ctrl_mem_write, ctrl_mem2reg, ctrl_reg_write, ctrl_alu_src;
    logic        ctrl_branch_taken, ctrl_auipc_taken;
    logic [2:0]  ctrl_store_size, ctrl_load_size;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_imm;
    logic [7:0]  ex_pc;
    logic [31:0] ex_rs1_data, ex_rs2_data, from_mem, from_wb;
    logic        ex_alu_src, ex_auipc_taken;
    logic [1:0]  fwd_left, fwd_right;
    logic [4:0]  ex_rd_sel;
    logic        ex_mem_write, ex_mem2reg, ex_reg_write;
    logic [2:0]  ex_load_size, ex_store_size;
    logic [31:0] alu_result, write_data, o_alu_result, o_write_data;
    logic [4:0]  o_rd_sel;
    logic        o_ctrl_mem_write, o_ctrl_mem2reg, o_ctrl_reg_write;
    logic [2:0]  o_ctrl_load_size, o_ctrl_store_size;

    int n_checks = 0;
    int n_fail   = 0;

    rv_ctrl_exec_slice #(.OPERAND_WIDTH(32), .PROGRAM_ADDRESS_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .ctrl_mem_write(ctrl_mem_write), .ctrl_mem2reg(ctrl_mem2reg),
        .ctrl_reg_write(ctrl_reg_write), .ctrl_alu_src(ctrl_alu_src),
        .ctrl_branch_taken(ctrl_branch_taken), .ctrl_auipc_taken(ctrl_auipc_taken),
        .ctrl_store_size(ctrl_store_size), .ctrl_load_size(ctrl_load_size),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .from_mem(from_mem), .from_wb(from_wb),
        .ex_alu_src(ex_alu_src), .ex_auipc_taken(ex_auipc_taken),
        .fwd_left(fwd_left), .fwd_right(fwd_right),
        .ex_rd_sel(ex_rd_sel),
        .ex_mem_write(ex_mem_write), .ex_mem2reg(ex_mem2reg), .ex_reg_write(ex_reg_write),
        .ex_load_size(ex_load_size), .ex_store_size(ex_store_size),
        .alu_result(alu_result), .write_data(write_data),
        .o_alu_result(o_alu_result), .o_write_data(o_write_data), .o_rd_sel(o_rd_sel),
        .o_ctrl_mem_write(o_ctrl_mem_write), .o_ctrl_mem2reg(o_ctrl_mem2reg),
        .o_ctrl_reg_write(o_ctrl_reg_write),
        .o_ctrl_load_size(o_ctrl_load_size), .o_ctrl_store_size(o_ctrl_store_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [7:0]  pc;
        logic        src;
        logic        auipc;
        logic [1:0]  fl;
        logic [1:0]  fr;
        logic [31:0] fm;
        logic [31:0] fw;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
    } ex_vec_t;

    // exp_ctl = {mem_write, mem2reg, reg_write, alu_src, branch_taken, auipc_taken}
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  exp_ctl;
        logic [2:0]  exp_ss;
        logic [2:0]  exp_ls;
    } id_vec_t;

    ex_vec_t ex_q[$];
    id_vec_t id_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_ex(input ex_vec_t v);
        ex_opcode      = v.op;
        ex_funct3      = v.f3;
        ex_funct7      = v.f7;
        ex_rs1_data    = v.rs1;
        ex_rs2_data    = v.rs2;
        ex_imm         = v.imm;
        ex_pc          = v.pc;
        ex_alu_src     = v.src;
        ex_auipc_taken = v.auipc;
        fwd_left       = v.fl;
        fwd_right      = v.fr;
        from_mem       = v.fm;
        from_wb        = v.fw;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, " o_alu_result"},      o_alu_result, 32'h0);
        check({tag, " o_write_data"},      o_write_data, 32'h0);
        check({tag, " o_rd_sel"},          {27'h0, o_rd_sel}, 32'h0);
        check({tag, " o_ctrl_mem_write"},  {31'h0, o_ctrl_mem_write}, 32'h0);
        check({tag, " o_ctrl_mem2reg"},    {31'h0, o_ctrl_mem2reg}, 32'h0);
        check({tag, " o_ctrl_reg_write"},  {31'h0, o_ctrl_reg_write}, 32'h0);
        check({tag, " o_ctrl_load_size"},  {29'h0, o_ctrl_load_size}, 32'h0);
        check({tag, " o_ctrl_store_size"}, {29'h0, o_ctrl_store_size}, 32'h0);
    endtask

    initial begin
        // ALU vectors: op f3 f7 rs1 rs2 imm pc src auipc fl fr fm fw exp_alu exp_wd
        ex_q.push_back('{OP,    3'b000, 7'h00, 32'd7, 32'd5, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd12, 32'd5});
        ex_q.push_back('{OP,    3'b000, 7'h20, 32'd7, 32'd5, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd2, 32'd5});
        ex_q.push_back('{OPIMM, 3'b000, 7'h7F, 32'd1, 32'd0, 32'hFFFF_FFFC, 8'h0, 1'b1, 1'b0, 2'd1, 2'd0, 32'd100, 32'h0, 32'd96, 32'd0});
        ex_q.push_back('{STORE, 3'b010, 7'h00, 32'h200, 32'h1, 32'd8, 8'h0, 1'b1, 1'b0, 2'd0, 2'd2, 32'h0, 32'hDEAD_BEEF, 32'h208, 32'hDEAD_BEEF});
        ex_q.push_back('{OP,    3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'hF800_0000, 32'd4});
        ex_q.push_back('{OP,    3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0800_0000, 32'd4});
        ex_q.push_back('{OP,    3'b011, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFF});
        ex_q.push_back('{OP,    3'b010, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd0, 32'hFFFF_FFFF});
        ex_q.push_back('{AUIPC, 3'b000, 7'h00, 32'h55, 32'h0, 32'h1000, 8'h10, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0, 32'h0, 32'h1010, 32'h0});
        ex_q.push_back('{LUI,   3'b000, 7'h00, 32'h55, 32'h0, 32'hABCD_E000, 8'h0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'hABCD_E000, 32'h0});
        ex_q.push_back('{OPIMM, 3'b000, 7'h20, 32'd10, 32'h0, 32'd3, 8'h0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd13, 32'h0});
        ex_q.push_back('{OPIMM, 3'b101, 7'h20, 32'hF000_0000, 32'h0, 32'h404, 8'h0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'hFF00_0000, 32'h0});
        ex_q.push_back('{JAL,   3'b000, 7'h00, 32'h0, 32'h0, 32'h40, 8'h20, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h24, 32'h0});
        ex_q.push_back('{JALR,  3'b000, 7'h00, 32'h300, 32'h0, 32'h8, 8'hFC, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h100, 32'h0});
        ex_q.push_back('{OP,    3'b100, 7'h00, 32'hF0F0, 32'h0FF0, 32'h0, 8'h0, 1'b0, 1'b0, 2'd3, 2'd3, 32'h1234, 32'h5678, 32'hFF00, 32'h0FF0});
        ex_q.push_back('{7'h7F, 3'b000, 7'h00, 32'h5, 32'h6, 32'h7, 8'h8, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h6});
        ex_q.push_back('{OP,    3'b001, 7'h00, 32'd1, 32'h25, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd32, 32'h25});
        ex_q.push_back('{OP,    3'b110, 7'h00, 32'hF0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 2'd0, 2'd1, 32'h0F, 32'h0, 32'hFF, 32'h0F});
        ex_q.push_back('{OP,    3'b111, 7'h00, 32'h0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 2'd2, 2'd2, 32'h0, 32'hFF0F, 32'hFF0F, 32'hFF0F});

        // Decoder vectors: op f3 rs1 rs2 exp_ctl exp_ss exp_ls
        id_q.push_back('{BRANCH, 3'b100, 32'hFFFF_FFFF, 32'd1, 6'b000010, 3'd0, 3'd0});
        id_q.push_back('{BRANCH, 3'b110, 32'hFFFF_FFFF, 32'd1, 6'b000000, 3'd0, 3'd0});
        id_q.push_back('{BRANCH, 3'b000, 32'd5, 32'd5, 6'b000010, 3'd0, 3'd0});
        id_q.push_back('{BRANCH, 3'b001, 32'd5, 32'd5, 6'b000000, 3'd0, 3'd0});
        id_q.push_back('{BRANCH, 3'b101, 32'hFFFF_FFFF, 32'd1, 6'b000000, 3'd0, 3'd0});
        id_q.push_back('{BRANCH, 3'b111, 32'hFFFF_FFFF, 32'd1, 6'b000010, 3'd0, 3'd0});
        id_q.push_back('{BRANCH, 3'b010, 32'd5, 32'd5, 6'b000000, 3'd0, 3'd0});
        id_q.push_back('{LOAD,   3'b100, 32'd0, 32'd0, 6'b011100, 3'd0, 3'b100});
        id_q.push_back('{STORE,  3'b001, 32'd0, 32'd0, 6'b100100, 3'b001, 3'd0});
        id_q.push_back('{AUIPC,  3'b011, 32'd0, 32'd0, 6'b001101, 3'd0, 3'd0});
        id_q.push_back('{JAL,    3'b000, 32'd0, 32'd0, 6'b001010, 3'd0, 3'd0});
        id_q.push_back('{OP,     3'b000, 32'd0, 32'd0, 6'b001000, 3'd0, 3'd0});
        id_q.push_back('{OPIMM,  3'b010, 32'd0, 32'd0, 6'b001100, 3'd0, 3'd0});
        id_q.push_back('{LUI,    3'b000, 32'd0, 32'd0, 6'b001100, 3'd0, 3'd0});
        id_q.push_back('{JALR,   3'b000, 32'd0, 32'd0, 6'b001100, 3'd0, 3'd0});
        id_q.push_back('{7'h00,  3'b010, 32'd5, 32'd5, 6'b000000, 3'd0, 3'd0});

        // Reset with every input nonzero
        rst = 1'b1;
        id_opcode = LOAD; id_funct3 = 3'b010; id_rs1_data = 32'd1; id_rs2_data = 32'd2;
        apply_ex(ex_q[0]);
        ex_rd_sel = 5'd9; ex_mem_write = 1'b1; ex_mem2reg = 1'b1; ex_reg_write = 1'b1;
        ex_load_size = 3'b111; ex_store_size = 3'b111;
        @(posedge clk); #1;
        check_regs_zero("reset");

        // ADD then SUB, SUB result captured by the register
        rst = 1'b0;
        ex_mem_write = 1'b0; ex_mem2reg = 1'b0; ex_load_size = 3'b000; ex_store_size = 3'b000;
        #1 check("add alu_result", alu_result, 32'd12);
        ex_funct7 = 7'h20;
        #1 check("sub alu_result", alu_result, 32'd2);
        @(posedge clk); #1;
        check("sub o_alu_result", o_alu_result, 32'd2);
        check("sub o_ctrl_reg_write", {31'h0, o_ctrl_reg_write}, 32'd1);
        check("sub o_rd_sel", {27'h0, o_rd_sel}, 32'd9);

        // Store with MEM/WB forwarding of the store data
        apply_ex(ex_q[3]);
        ex_rd_sel = 5'd0; ex_reg_write = 1'b0; ex_mem_write = 1'b1; ex_store_size = 3'b010;
        @(posedge clk); #1;
        check("store o_write_data", o_write_data, 32'hDEAD_BEEF);
        check("store o_alu_result", o_alu_result, 32'h208);
        check("store o_ctrl_mem_write", {31'h0, o_ctrl_mem_write}, 32'd1);
        check("store o_ctrl_store_size", {29'h0, o_ctrl_store_size}, 32'd2);
        check("store o_ctrl_reg_write", {31'h0, o_ctrl_reg_write}, 32'd0);

        // Load controls propagate
        ex_opcode = LOAD; ex_mem_write = 1'b0; ex_store_size = 3'b000;
        ex_mem2reg = 1'b1; ex_reg_write = 1'b1; ex_load_size = 3'b100; ex_rd_sel = 5'd31;
        @(posedge clk); #1;
        check("load o_ctrl_mem2reg", {31'h0, o_ctrl_mem2reg}, 32'd1);
        check("load o_ctrl_load_size", {29'h0, o_ctrl_load_size}, 32'd4);
        check("load o_rd_sel", {27'h0, o_rd_sel}, 32'd31);
        check("load o_ctrl_mem_write", {31'h0, o_ctrl_mem_write}, 32'd0);

        // Mid-stream reset clears the register but not the combinational path
        rst = 1'b1;
        @(posedge clk); #1;
        check_regs_zero("midreset");
        check("midreset alu_result", alu_result, 32'h208);
        rst = 1'b0;
        ex_mem2reg = 1'b0; ex_reg_write = 1'b0; ex_load_size = 3'b000;

        // Table-driven ALU vectors, each also checked through the register
        foreach (ex_q[i]) begin
            apply_ex(ex_q[i]);
            ex_rd_sel = 5'(i);
            #1;
            check($sformatf("ex[%0d] alu_result", i), alu_result, ex_q[i].exp_alu);
            check($sformatf("ex[%0d] write_data", i), write_data, ex_q[i].exp_wd);
            @(posedge clk); #1;
            check($sformatf("ex[%0d] o_alu_result", i), o_alu_result, ex_q[i].exp_alu);
            check($sformatf("ex[%0d] o_write_data", i), o_write_data, ex_q[i].exp_wd);
            check($sformatf("ex[%0d] o_rd_sel", i), {27'h0, o_rd_sel}, {27'h0, 5'(i)});
        end

        // Table-driven decoder vectors
        foreach (id_q[i]) begin
            id_opcode   = id_q[i].op;
            id_funct3   = id_q[i].f3;
            id_rs1_data = id_q[i].rs1;
            id_rs2_data = id_q[i].rs2;
            #1;
            check($sformatf("id[%0d] ctrl", i),
                  {26'h0, ctrl_mem_write, ctrl_mem2reg, ctrl_reg_write,
                   ctrl_alu_src, ctrl_branch_taken, ctrl_auipc_taken},
                  {26'h0, id_q[i].exp_ctl});
            check($sformatf("id[%0d] store_size", i), {29'h0, ctrl_store_size}, {29'h0, id_q[i].exp_ss});
            check($sformatf("id[%0d] load_size", i), {29'h0, ctrl_load_size}, {29'h0, id_q[i].exp_ls});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
